gpio_matrix_responder: RTL and testbench

- Device-side end of the GPIO matrix link: sits between the board GPIO pins and the matrix compute core.
- Receives MATRIX_SIZE input elements from gpio_switch via a toggle handshake, captures the mode bit and hands the frame to the core.
- Streams the core's MATRIX_SIZE results back on gpio_led, one element per host acknowledge.

---
 rtl/gpio_matrix_responder_if.sv | 28 ++
 rtl/gpio_matrix_responder.sv | 128 ++++++++++++
 tb/tb_gpio_matrix_responder.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/gpio_matrix_responder_if.sv
// Core-side link of the GPIO matrix responder: frame out, start/done handshake, results in.
// The master modport is the responder; the slave modport is the compute core.
interface gpio_matrix_responder_if #(
  parameter int unsigned MATRIX_SIZE = 16,
  parameter int unsigned DATA_W      = 14
);
  logic [MATRIX_SIZE*DATA_W-1:0] core_in_o;
  logic                          core_mode_o;
  logic                          core_start_o;
  logic                          core_done_i;
  logic [MATRIX_SIZE*DATA_W-1:0] core_res_i;

  modport master (
    output core_in_o,
    output core_mode_o,
    output core_start_o,
    input  core_done_i,
    input  core_res_i
  );

  modport slave (
    input  core_in_o,
    input  core_mode_o,
    input  core_start_o,
    output core_done_i,
    output core_res_i
  );
endinterface

// File: rtl/gpio_matrix_responder.sv
// Device end of the GPIO matrix link: collects a frame from the switch pins with a
// toggle handshake, launches the core, then streams results back out on the LEDs.
module gpio_matrix_responder #(
  parameter int unsigned MATRIX_SIZE = 16,
  parameter int unsigned DATA_W      = 14
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [15:0]              gpio_switch,
  output logic [15:0]              gpio_led,
  gpio_matrix_responder_if.master  core,
  output logic [7:0]               frame_cnt_o,
  output logic                     proto_err_o
);

  localparam int unsigned IDX_W = $clog2(MATRIX_SIZE);
  localparam int unsigned BUF_W = MATRIX_SIZE * DATA_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MATRIX_SIZE - 1);

  localparam logic [2:0] RECV      = 3'd0;
  localparam logic [2:0] LAUNCH    = 3'd1;
  localparam logic [2:0] WAIT_CORE = 3'd2;
  localparam logic [2:0] SEND      = 3'd3;
  localparam logic [2:0] DONE      = 3'd4;

  logic [2:0]       state;
  logic [15:0]      s1;
  logic [15:0]      s2;
  logic             strobe_prev;
  logic             strobe_edge;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic [BUF_W-1:0] in_buf;
  logic [BUF_W-1:0] res_buf;
  logic [15:0]      led_q;
  logic [7:0]       cnt_q;
  logic             mode_q;
  logic             start_q;
  logic             err_q;

  assign strobe_edge = s2[15] ^ strobe_prev;
  assign idx_nxt     = idx + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= RECV;
      s1          <= '0;
      s2          <= '0;
      strobe_prev <= 1'b0;
      idx         <= '0;
      in_buf      <= '0;
      res_buf     <= '0;
      led_q       <= '0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      start_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      s1          <= gpio_switch;
      s2          <= s1;
      strobe_prev <= s2[15];
      start_q     <= 1'b0;

      case (state)
        RECV: begin
          if (strobe_edge) begin
            in_buf[idx*DATA_W +: DATA_W] <= s2[14:1];
            if (idx == '0) mode_q <= s2[0];
            led_q[15] <= ~led_q[15];
            // Start is raised on the way into LAUNCH so it is high exactly while in LAUNCH.
            if (idx == LAST_IDX) begin
              idx     <= '0;
              state   <= LAUNCH;
              start_q <= 1'b1;
            end else begin
              idx <= idx_nxt;
            end
          end
        end

        LAUNCH: state <= WAIT_CORE;

        WAIT_CORE: begin
          if (core.core_done_i) begin
            res_buf         <= core.core_res_i;
            led_q[13:0]     <= core.core_res_i[DATA_W-1:0];
            led_q[14]       <= ~led_q[14];
            state           <= SEND;
          end
        end

        SEND: begin
          if (strobe_edge) begin
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= DONE;
            end else begin
              idx         <= idx_nxt;
              led_q[13:0] <= res_buf[idx_nxt*DATA_W +: DATA_W];
              led_q[14]   <= ~led_q[14];
            end
          end
        end

        DONE: begin
          cnt_q <= cnt_q + 8'd1;
          idx   <= '0;
          state <= RECV;
        end

        default: state <= RECV;
      endcase

      if (strobe_edge && (state == LAUNCH || state == WAIT_CORE || state == DONE))
        err_q <= 1'b1;
      if (core.core_done_i && state != WAIT_CORE)
        err_q <= 1'b1;
    end
  end

  assign gpio_led          = led_q;
  assign frame_cnt_o       = cnt_q;
  assign proto_err_o       = err_q;
  assign core.core_in_o    = in_buf;
  assign core.core_mode_o  = mode_q;
  assign core.core_start_o = start_q;

endmodule

// File: tb/tb_gpio_matrix_responder.sv
// Directed bench for gpio_matrix_responder: host and core are driven from one sequence,
// which schedules the expected output changes; a negedge process compares every cycle.
module tb_gpio_matrix_responder;
  localparam int unsigned MS = 16;
  localparam int unsigned DW = 14;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] gpio_switch;
  logic [15:0] gpio_led;
  logic [7:0]  frame_cnt_o;
  logic        proto_err_o;

  gpio_matrix_responder_if #(.MATRIX_SIZE(MS), .DATA_W(DW)) core_if ();

  gpio_matrix_responder #(.MATRIX_SIZE(MS), .DATA_W(DW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .gpio_switch (gpio_switch),
    .gpio_led    (gpio_led),
    .core        (core_if),
    .frame_cnt_o (frame_cnt_o),
    .proto_err_o (proto_err_o)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic        model_on = 1'b0;
  logic [15:0] exp_led;
  logic [7:0]  exp_cnt;
  logic        exp_err;
  logic        exp_mode;
  logic        exp_start;
  logic        sw_strobe;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      check("led",   32'(gpio_led),              32'(exp_led));
      check("cnt",   32'(frame_cnt_o),           32'(exp_cnt));
      check("err",   32'(proto_err_o),           32'(exp_err));
      check("mode",  32'(core_if.core_mode_o),   32'(exp_mode));
      check("start", 32'(core_if.core_start_o),  32'(exp_start));
    end
  end

  task automatic host_toggle(input logic [13:0] d, input logic m);
    sw_strobe   = ~sw_strobe;
    gpio_switch = {sw_strobe, d, m};
  endtask

  // Called #1 after a posedge; reset takes effect on the next edge.
  task automatic do_reset();
    gpio_switch = '0;
    sw_strobe   = 1'b0;
    rst         = 1'b1;
    @(posedge clk);
    exp_led = '0; exp_cnt = '0; exp_err = 1'b0; exp_mode = 1'b0; exp_start = 1'b0;
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Sends element k: the ack toggle must land on the third edge after the pin change.
  task automatic send_elem(input int unsigned k, input logic [13:0] d, input logic m);
    host_toggle(d, m);
    repeat (3) @(posedge clk);
    exp_led[15] = ~exp_led[15];
    if (k == 0) exp_mode = m;
    if (k == MS - 1) exp_start = 1'b1;
    #1;
  endtask

  task automatic run_frame(input int unsigned in_base, input int unsigned res_base,
                           input logic m0, input int flip_at, input logic m_flip,
                           input bit inject);
    logic m;
    m = m0;
    for (int k = 0; k < MS; k++) begin
      m = (flip_at >= 0 && k >= flip_at) ? m_flip : m0;
      send_elem(k, 14'(in_base + k), m);
    end
    for (int k = 0; k < MS; k++)
      check("core_in", 32'(core_if.core_in_o[k*DW +: DW]), 32'(14'(in_base + k)));
    @(posedge clk);
    exp_start = 1'b0;
    #1;
    // Core answers ten edges after start was seen.
    if (inject) begin
      host_toggle(14'd0, m);
      repeat (3) @(posedge clk);
      exp_err = 1'b1;
      #1;
      repeat (5) @(posedge clk);
      #1;
    end else begin
      repeat (8) @(posedge clk);
      #1;
    end
    for (int k = 0; k < MS; k++)
      core_if.core_res_i[k*DW +: DW] = 14'(res_base + k);
    core_if.core_done_i = 1'b1;
    @(posedge clk);
    exp_led[14]   = ~exp_led[14];
    exp_led[13:0] = 14'(res_base);
    #1;
    core_if.core_done_i = 1'b0;
    check("first_res", 32'(gpio_led[13:0]), 32'(14'(res_base)));
    for (int k = 0; k < MS; k++) begin
      host_toggle(14'd0, m);
      repeat (3) @(posedge clk);
      if (k < MS - 1) begin
        exp_led[14]   = ~exp_led[14];
        exp_led[13:0] = 14'(res_base + k + 1);
      end
      #1;
    end
    @(posedge clk);
    exp_cnt = exp_cnt + 8'd1;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    gpio_switch = '0;
    sw_strobe = 1'b0;
    core_if.core_done_i = 1'b0;
    core_if.core_res_i  = '0;
    exp_led = '0; exp_cnt = '0; exp_err = 1'b0; exp_mode = 1'b0; exp_start = 1'b0;
    repeat (2) @(posedge clk);
    model_on = 1'b1;
    #1;
    rst = 1'b0;
    check("rst_led", 32'(gpio_led), 32'h0);
    check("rst_cnt", 32'(frame_cnt_o), 32'h0);

    // Basic frame: inputs 1..16 mode 0, results 100..115.
    run_frame(1, 100, 1'b0, -1, 1'b0, 1'b0);
    check("f1_cnt",  32'(frame_cnt_o), 32'd1);
    check("f1_led",  32'(gpio_led), 32'h0073);
    check("f1_e0",   32'(core_if.core_in_o[13:0]), 32'd1);
    check("f1_e15",  32'(core_if.core_in_o[15*DW +: DW]), 32'd16);
    check("f1_mode", 32'(core_if.core_mode_o), 32'd0);

    // Mode 1 latched from element 0 survives a flip at element 5.
    run_frame(200, 300, 1'b1, 5, 1'b0, 1'b0);
    check("f2_mode", 32'(core_if.core_mode_o), 32'd1);
    run_frame(400, 500, 1'b0, -1, 1'b0, 1'b0);
    check("f3_mode", 32'(core_if.core_mode_o), 32'd0);
    check("f3_cnt",  32'(frame_cnt_o), 32'd3);

    // Reset after element 7, then a fresh frame.
    for (int k = 0; k < 8; k++) send_elem(k, 14'(1000 + k), 1'b1);
    do_reset();
    check("mid_rst_in",   32'(core_if.core_in_o[13:0]), 32'd0);
    check("mid_rst_led",  32'(gpio_led), 32'd0);
    check("mid_rst_mode", 32'(core_if.core_mode_o), 32'd0);
    run_frame(2000, 3000, 1'b0, -1, 1'b0, 1'b0);
    check("post_rst_cnt", 32'(frame_cnt_o), 32'd1);

    // Stray strobe while the core is busy; flag is sticky across the next frame.
    run_frame(50, 60, 1'b1, -1, 1'b1, 1'b1);
    check("err_set", 32'(proto_err_o), 32'd1);
    check("err_res", 32'(gpio_led[13:0]), 32'd75);
    run_frame(70, 80, 1'b0, -1, 1'b0, 1'b0);
    check("err_sticky", 32'(proto_err_o), 32'd1);

    // 256 back-to-back frames wrap the counter.
    do_reset();
    for (int f = 0; f < 256; f++)
      run_frame((f * 16) & 16'h3fff, (f * 7 + 9) & 16'h3fff, f[0], -1, 1'b0, 1'b0);
    check("wrap_cnt", 32'(frame_cnt_o), 32'd0);
    check("wrap_err", 32'(proto_err_o), 32'd0);

    model_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
